// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential double-dabble BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int BCD_DIGITS = 4;
    localparam logic [3:0] BCD_MINUS = 4'hA;

    // Width of a down-counter that has to hold the value data_w.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a nibble of 5 or more gets 3 added before the shift.
module bcd_add3 (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    // Inputs never exceed 9, so the 4-bit sum tops out at 12 and cannot carry.
    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/bcd_converter.sv
// Sequential binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Define BCD_SIGNED_EN to treat bin_in as two's complement (magnitude + neg + minus code).
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        out1,
    output logic [3:0]        out2,
    output logic [3:0]        out3,
    output logic [3:0]        out4,
    output logic              neg
);

`ifdef BCD_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam int CNT_W = cnt_width(DATA_W);
    localparam int SCR_W = 4 * BCD_DIGITS;

    state_t              state;
    logic [DATA_W-1:0]   shreg;
    logic [SCR_W-1:0]    scratch;
    logic [SCR_W-1:0]    adj;
    logic [CNT_W-1:0]    cnt;
    logic                sign;

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .digit    (scratch[4*i +: 4]),
            .adjusted (adj[4*i +: 4])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            neg     <= 1'b0;
            out1    <= '0;
            out2    <= '0;
            out3    <= '0;
            out4    <= '0;
            shreg   <= '0;
            scratch <= '0;
            cnt     <= '0;
            sign    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (SIGNED_EN && bin_in[DATA_W-1]) begin
                            sign  <= 1'b1;
                            shreg <= ~bin_in + DATA_W'(1);
                        end else begin
                            sign  <= 1'b0;
                            shreg <= bin_in;
                        end
                        scratch <= '0;
                        cnt     <= CNT_W'(DATA_W);
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= {adj[SCR_W-2:0], shreg[DATA_W-1]};
                    shreg   <= {shreg[DATA_W-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    out1  <= scratch[3:0];
                    out2  <= scratch[7:4];
                    out3  <= scratch[11:8];
                    out4  <= sign ? BCD_MINUS : scratch[15:12];
                    neg   <= sign;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_converter.sv
// Self-checking bench for bcd_converter (DATA_W=8); honours BCD_SIGNED_EN when defined.
module tb_bcd_converter;

    localparam int DATA_W  = 8;
    localparam int LATENCY = DATA_W + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] bin_in = '0;
    logic       busy, done, neg;
    logic [3:0] out1, out2, out3, out4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bcd_converter #(.DATA_W(DATA_W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bin_in (bin_in),
        .busy   (busy),
        .done   (done),
        .out1   (out1),
        .out2   (out2),
        .out3   (out3),
        .out4   (out4),
        .neg    (neg)
    );

    // Reference: decimal digits by plain division, {neg, out4, out3, out2, out1}.
    function automatic logic [16:0] model(input logic [7:0] b);
        int   v;
        logic n;
        v = int'(b);
        n = 1'b0;
`ifdef BCD_SIGNED_EN
        if (b >= 8'd128) begin
            v = 256 - int'(b);
            n = 1'b1;
        end
`endif
        return {n, (n ? 4'hA : 4'((v / 1000) % 10)), 4'((v / 100) % 10),
                4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [16:0] result_now();
        return {neg, out4, out3, out2, out1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] v);
        start  = 1'b1;
        bin_in = v;
        step();
        start  = 1'b0;
        bin_in = 8'($urandom);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (done) break;
        end
    endtask

    task automatic test_reset();
        int n;
        reset  = 1'b1;
        start  = 1'b1;
        bin_in = 8'd255;
        repeat (3) step();
        checks++;
        if ({busy, done, result_now()} !== 19'h0) begin
            failures++;
            $display("FAIL reset_state: got busy=%b done=%b res=%h, expected all zero", busy, done, result_now());
        end
        reset = 1'b0;
        start = 1'b0;
        n = 0;
        repeat (12) begin
            step();
            if (busy || done) n++;
        end
        checks++;
        if (n !== 0) begin
            failures++;
            $display("FAIL start_during_reset: got %0d busy/done cycles, expected 0", n);
        end
    endtask

    task automatic test_vectors();
        int n;
        logic [16:0] prev;
        logic [7:0] vals [3];
        vals = '{8'd255, 8'd0, 8'd99};
        foreach (vals[k]) begin
            prev = result_now();
            launch(vals[k]);
            n = 0;
            while (!done && n < 40) begin
                checks++;
                if (result_now() !== prev) begin
                    failures++;
                    $display("FAIL hold_%0d: got %h, expected previous %h", vals[k], result_now(), prev);
                end
                step();
                n++;
            end
            checks++;
            if (n !== LATENCY) begin
                failures++;
                $display("FAIL latency_%0d: got %0d cycles, expected %0d", vals[k], n, LATENCY);
            end
            checks++;
            if (result_now() !== model(vals[k])) begin
                failures++;
                $display("FAIL result_%0d: got %h, expected %h", vals[k], result_now(), model(vals[k]));
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL busy_in_done_%0d: got %b, expected 0", vals[k], busy);
            end
            step();
            checks++;
            if (done !== 1'b0) begin
                failures++;
                $display("FAIL done_pulse_%0d: got %b, expected 0", vals[k], done);
            end
        end
`ifndef BCD_SIGNED_EN
        checks++;
        if (result_now() !== 17'h00099) begin
            failures++;
            $display("FAIL const_99: got %h, expected 00099", result_now());
        end
`endif
    endtask

    task automatic test_busy_ignore();
        int n;
        int dones;
        start  = 1'b1;
        bin_in = 8'd42;
        step();
        bin_in = 8'd7;
        n = 0;
        dones = 0;
        while (n < 40) begin
            step();
            n++;
            if (done) begin
                dones++;
                break;
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL busy_hold: got %b at cycle %0d, expected 1", busy, n);
            end
        end
        checks++;
        if (n !== LATENCY || dones !== 1) begin
            failures++;
            $display("FAIL busy_ignore_latency: got %0d cycles %0d dones, expected %0d and 1", n, dones, LATENCY);
        end
        checks++;
        if (result_now() !== model(8'd42)) begin
            failures++;
            $display("FAIL busy_ignore_result: got %h, expected %h", result_now(), model(8'd42));
        end
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL restart_after_done: got busy=%b done=%b, expected 1 0", busy, done);
        end
        wait_done(n);
        checks++;
        if (n !== LATENCY || result_now() !== model(8'd7)) begin
            failures++;
            $display("FAIL second_capture: got %0d cycles res %h, expected %0d res %h", n, result_now(), LATENCY, model(8'd7));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] v;
        for (int i = 0; i < 6; i++) begin
            v = 8'($urandom);
            launch(v);
            wait_done(n);
            checks++;
            if (n !== LATENCY || result_now() !== model(v)) begin
                failures++;
                $display("FAIL back_to_back_%0d: got %0d cycles res %h, expected %0d res %h", v, n, result_now(), LATENCY, model(v));
            end
        end
    endtask

    task automatic test_random();
        int n;
        int gap;
        logic [7:0] v;
        logic [16:0] prev;
        for (int i = 0; i < 30; i++) begin
            v = 8'($urandom);
            gap = int'($urandom_range(0, 3));
            prev = result_now();
            repeat (gap) step();
            checks++;
            if (busy !== 1'b0 || result_now() !== prev) begin
                failures++;
                $display("FAIL idle_gap: got busy=%b res=%h, expected 0 res %h", busy, result_now(), prev);
            end
            launch(v);
            wait_done(n);
            checks++;
            if (n !== LATENCY || result_now() !== model(v)) begin
                failures++;
                $display("FAIL random_%0d: got %0d cycles res %h, expected %0d res %h", v, n, result_now(), LATENCY, model(v));
            end
        end
    endtask

    task automatic test_reset_abort();
        int n;
        int dones;
        launch(8'd123);
        wait_done(n);
        checks++;
        if (result_now() !== model(8'd123)) begin
            failures++;
            $display("FAIL pre_abort: got %h, expected %h", result_now(), model(8'd123));
        end
        launch(8'd201);
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_now() !== 17'h0) begin
            failures++;
            $display("FAIL abort_state: got busy=%b res=%h, expected 0 res 00000", busy, result_now());
        end
        dones = 0;
        repeat (12) begin
            step();
            if (done) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d dones busy=%b, expected 0 and 0", dones, busy);
        end
        launch(8'd173);
        wait_done(n);
        checks++;
        if (n !== LATENCY || result_now() !== model(8'd173)) begin
            failures++;
            $display("FAIL after_abort: got %0d cycles res %h, expected %0d res %h", n, result_now(), LATENCY, model(8'd173));
        end
    endtask

`ifdef BCD_SIGNED_EN
    task automatic test_signed();
        int n;
        logic [7:0]  vals [3];
        logic [16:0] exp  [3];
        vals = '{8'hF6, 8'h80, 8'h7F};
        exp  = '{17'h1A010, 17'h1A128, 17'h00127};
        foreach (vals[k]) begin
            launch(vals[k]);
            wait_done(n);
            checks++;
            if (n !== LATENCY || result_now() !== exp[k]) begin
                failures++;
                $display("FAIL signed_%h: got %0d cycles res %h, expected %0d res %h", vals[k], n, result_now(), LATENCY, exp[k]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_busy_ignore();
        test_back_to_back();
        test_random();
        test_reset_abort();
`ifdef BCD_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
